bus_arbiter2: RTL and testbench
===============================

// Module: bus_arbiter2
// PURPOSE
//  Two-master arbiter placed directly upstream of a single bus slave (peripheral).
//  Serialises requests from two controllers onto one slave bus (trans/write/waddr/wdata in,
//  readyout/rdata back), using round-robin grant.
//  Returns each response only to the master that owns it, with an optional timeout.
// PARAMETERS
//  AW       8   address width
//  DW       8   data width
//  TIMEOUT  15  max WAIT cycles before error response; 0 = no timeout
// PORTS
//  clock        in   1   single clock, all state on posedge
//  rst          in   1   reset: synchronous, active-high
//  m0_trans     in   1   master 0 request; held high until m0_readyout seen
//  m0_write     in   1   master 0: 1 = write, 0 = read
//  m0_waddr     in   AW  master 0 address
//  m0_wdata     in   DW  master 0 write data
//  m0_readyout  out  1   one-cycle response pulse to master 0
//  m0_rdata     out  DW  response data to master 0; valid while m0_readyout=1
//  m0_err       out  1   timeout flag, qualifies m0_readyout
//  m1_*         --   --  same seven ports for master 1
//  s_trans      out  1   slave request, one-cycle pulse per transaction
//  s_write      out  1   forwarded write flag
//  s_waddr      out  AW  forwarded address
//  s_wdata      out  DW  forwarded write data
//  s_readyout   in   1   slave response valid
//  s_rdata      in   DW  slave response data
// BEHAVIOUR
//  - All outputs registered.
//  - Reset values: all outputs 0, state=IDLE, last_grant=1 (master 0 wins first tie),
//    timeout counter 0.
//  - States:
//    IDLE:  if any mX_trans, grant one master and latch its write/waddr/wdata into s_*;
//           s_trans<=1; go to ISSUE.
//           Both requesting: grant != last_grant. One requesting: grant it.
//    ISSUE: s_trans<=0; clear counter; go to WAIT.
//    WAIT:  on s_readyout=1: mG_rdata<=s_rdata, mG_readyout<=1, mG_err<=0; go to RESP.
//           Otherwise counter++.
//           TIMEOUT!=0 and counter==TIMEOUT-1 with no s_readyout:
//           mG_rdata<={DW{1'b1}}, mG_readyout<=1, mG_err<=1; go to RESP.
//    RESP:  clear mG_readyout/mG_err; last_grant<=G; go to IDLE.
//  - Latency: request seen in IDLE cycle N -> s_trans=1 in N+1.
//    With a 1-cycle registered slave: s_readyout=1 in N+2, mG_readyout=1 in N+3.
//  - s_* fields stay stable from ISSUE through RESP. Only the granted master ever sees
//    readyout; the other master's m_readyout stays 0.
//  - A non-granted request stays pending; no queue.
//    Request dropped before grant: ignored, no response.
//    mX_trans still high in IDLE after its RESP: treated as a new request.
//  - Granted master's inputs are not re-sampled after IDLE.
//    Changes mid-transaction do not affect s_*.
//  - s_readyout outside WAIT: ignored.
//    s_readyout and the timeout expiry in the same cycle: data wins, err=0.
//  - rst mid-transaction: next cycle everything is at reset values (s_trans=0,
//    no response pulse). The in-flight response is discarded.
// TESTING
//  Slave for all tests: the team's even/odd mode peripheral (even mode: rdata=waddr>>1).
//  1. m0 read waddr=8'h10 alone -> s_trans pulse at N+1, m0_readyout=1 at N+3,
//     m0_rdata=8'h08, m1_readyout stays 0.
//  2. m0 and m1 both request from reset in the same cycle -> m0 served first,
//     then m1 (round-robin). Sustained dual requests alternate 0,1,0,1.
//  3. m1 write waddr=8'h00 wdata=8'h01, then m0 read waddr=8'h05
//     -> m0_rdata=8'h10 (odd mode: 3*5+1).
//  4. Slave tied s_readyout=0, TIMEOUT=15 -> m0_readyout with m0_err=1,
//     m0_rdata=8'hFF exactly 15 cycles after WAIT entry; then back to IDLE.
//  5. rst asserted in WAIT -> next cycle all outputs 0 and state IDLE;
//     a late s_readyout produces no m_readyout.
//  6. Change m0_waddr during WAIT -> s_waddr unchanged; response matches the
//     originally latched address.

Source files
------------

// File: rtl/bus_arbiter2.sv
// bus_arbiter2
//   Two-master round-robin arbiter in front of one bus slave. Each transaction
//   is forwarded as a single-cycle s_trans pulse. The response goes back only to
//   the master that was granted. If the slave does not answer within TIMEOUT
//   cycles, the master gets an error response instead.
//
// Ports
//   clock, rst                     clock and synchronous active-high reset
//   mX_trans/write/waddr/wdata     master X request (held until mX_readyout)
//   mX_readyout/rdata/err          master X one-cycle response, err = timeout
//   s_trans/write/waddr/wdata      registered request towards the slave
//   s_readyout/rdata               slave response
module bus_arbiter2 #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          m0_trans,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_waddr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_readyout,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_trans,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_waddr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_readyout,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          s_trans,
  output logic          s_write,
  output logic [AW-1:0] s_waddr,
  output logic [DW-1:0] s_wdata,
  input  logic          s_readyout,
  input  logic [DW-1:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // The counter only needs to reach TIMEOUT-1 before the FSM leaves WAIT.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s_trans_q, s_trans_d;
  logic            s_write_q, s_write_d;
  logic [AW-1:0]   s_waddr_q, s_waddr_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;
  logic            m0_rdy_q, m0_rdy_d, m1_rdy_q, m1_rdy_d;
  logic            m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [DW-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic            gnt_sel;
  logic            resp_fire;
  logic            resp_err;
  logic [DW-1:0]   resp_data;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    s_trans_d    = s_trans_q;
    s_write_d    = s_write_q;
    s_waddr_d    = s_waddr_q;
    s_wdata_d    = s_wdata_q;
    m0_rdy_d     = m0_rdy_q;
    m1_rdy_d     = m1_rdy_q;
    m0_err_d     = m0_err_q;
    m1_err_d     = m1_err_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    gnt_sel      = 1'b0;
    resp_fire    = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;

    case (state_q)
      IDLE: begin
        if (m0_trans || m1_trans) begin
          // A tie goes to the master that was not served last.
          gnt_sel   = (m0_trans && m1_trans) ? ~last_grant_q : m1_trans;
          grant_d   = gnt_sel;
          s_trans_d = 1'b1;
          s_write_d = gnt_sel ? m1_write : m0_write;
          s_waddr_d = gnt_sel ? m1_waddr : m0_waddr;
          s_wdata_d = gnt_sel ? m1_wdata : m0_wdata;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        s_trans_d = 1'b0;
        cnt_d     = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // Slave data has priority over a timeout that expires in the same cycle.
        if (s_readyout) begin
          resp_fire = 1'b1;
          resp_data = s_rdata;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          resp_data = {DW{1'b1}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (resp_fire) begin
          if (grant_q) begin
            m1_rdy_d   = 1'b1;
            m1_err_d   = resp_err;
            m1_rdata_d = resp_data;
          end else begin
            m0_rdy_d   = 1'b1;
            m0_err_d   = resp_err;
            m0_rdata_d = resp_data;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        m0_rdy_d     = 1'b0;
        m1_rdy_d     = 1'b0;
        m0_err_d     = 1'b0;
        m1_err_d     = 1'b0;
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      s_trans_q    <= 1'b0;
      s_write_q    <= 1'b0;
      s_waddr_q    <= '0;
      s_wdata_q    <= '0;
      m0_rdy_q     <= 1'b0;
      m1_rdy_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      s_trans_q    <= s_trans_d;
      s_write_q    <= s_write_d;
      s_waddr_q    <= s_waddr_d;
      s_wdata_q    <= s_wdata_d;
      m0_rdy_q     <= m0_rdy_d;
      m1_rdy_q     <= m1_rdy_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign s_trans     = s_trans_q;
  assign s_write     = s_write_q;
  assign s_waddr     = s_waddr_q;
  assign s_wdata     = s_wdata_q;
  assign m0_readyout = m0_rdy_q;
  assign m0_rdata    = m0_rdata_q;
  assign m0_err      = m0_err_q;
  assign m1_readyout = m1_rdy_q;
  assign m1_rdata    = m1_rdata_q;
  assign m1_err      = m1_err_q;

endmodule

// File: tb/tb_bus_arbiter2.sv
module tb_bus_arbiter2;

  logic       clock = 1'b0;
  logic       rst;
  logic       m0_trans, m0_write, m1_trans, m1_write;
  logic [7:0] m0_waddr, m0_wdata, m1_waddr, m1_wdata;
  logic       m0_readyout, m0_err, m1_readyout, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic       s_trans, s_write, s_readyout;
  logic [7:0] s_waddr, s_wdata, s_rdata;

  int checks = 0;
  int errors = 0;

  // Even/odd mode peripheral: write of addr 0 sets mode = wdata[0];
  // reads return waddr>>1 in even mode, 3*waddr+1 in odd mode, one cycle later.
  logic       slv_rdy, slv_mode, mute, inj;
  logic [7:0] slv_rdata, inj_data;

  always_ff @(posedge clock) begin
    if (rst) begin
      slv_rdy   <= 1'b0;
      slv_mode  <= 1'b0;
      slv_rdata <= 8'h00;
    end else begin
      slv_rdy <= s_trans;
      if (s_trans) begin
        if (s_write) begin
          if (s_waddr == 8'h00) slv_mode <= s_wdata[0];
          slv_rdata <= 8'h00;
        end else begin
          slv_rdata <= slv_mode ? 8'(8'd3 * s_waddr + 8'd1) : (s_waddr >> 1);
        end
      end
    end
  end

  assign s_readyout = (slv_rdy & ~mute) | inj;
  assign s_rdata    = inj ? inj_data : slv_rdata;

  bus_arbiter2 #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
    .clock(clock), .rst(rst),
    .m0_trans(m0_trans), .m0_write(m0_write), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata),
    .m0_readyout(m0_readyout), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_trans(m1_trans), .m1_write(m1_write), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata),
    .m1_readyout(m1_readyout), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_trans(s_trans), .s_write(s_write), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .s_readyout(s_readyout), .s_rdata(s_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  // Waits up to budget negedges for a response; who = 0/1, 2 if both, -1 if none.
  task automatic wait_resp(input int budget, output int who, output int cyc);
    who = -1;
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clock);
      cyc = i;
      if (m0_readyout && m1_readyout) begin who = 2; break; end
      if (m0_readyout) begin who = 0; break; end
      if (m1_readyout) begin who = 1; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    m0_trans = 0; m0_write = 0; m0_waddr = 0; m0_wdata = 0;
    m1_trans = 0; m1_write = 0; m1_waddr = 0; m1_wdata = 0;
    mute = 0; inj = 0; inj_data = 0;
    rst = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({s_trans, s_write, s_waddr, s_wdata, m0_readyout, m0_err, m0_rdata,
         m1_readyout, m1_err, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got s_trans=%b s_waddr=%h m0_rdy=%b m1_rdy=%b, required all 0",
               s_trans, s_waddr, m0_readyout, m1_readyout);
    end
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_read();
    m0_trans = 1; m0_write = 0; m0_waddr = 8'h10;
    @(negedge clock);
    checks++;
    if (s_trans !== 1'b1 || s_write !== 1'b0 || s_waddr !== 8'h10) begin
      errors++;
      $display("FAIL single_issue: got s_trans=%b s_write=%b s_waddr=%h, required 1 0 10",
               s_trans, s_write, s_waddr);
    end
    @(negedge clock);
    checks++;
    if (s_trans !== 1'b0 || m0_readyout !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: got s_trans=%b m0_readyout=%b, required 0 0", s_trans, m0_readyout);
    end
    @(negedge clock);
    checks++;
    if (m0_readyout !== 1'b1 || m0_rdata !== 8'h08 || m0_err !== 1'b0 || m1_readyout !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got m0_rdy=%b rdata=%h err=%b m1_rdy=%b, required 1 08 0 0",
               m0_readyout, m0_rdata, m0_err, m1_readyout);
    end
    m0_trans = 0;
    @(negedge clock);
    checks++;
    if (m0_readyout !== 1'b0 || s_waddr !== 8'h10) begin
      errors++;
      $display("FAIL single_pulse: got m0_rdy=%b s_waddr=%h, required 0 10", m0_readyout, s_waddr);
    end
  endtask

  task automatic test_round_robin();
    int who, cyc;
    logic [7:0] exp_data;
    do_reset();
    m0_trans = 1; m0_write = 0; m0_waddr = 8'h10;
    m1_trans = 1; m1_write = 0; m1_waddr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      wait_resp(10, who, cyc);
      exp_data = (k % 2 == 0) ? 8'h08 : 8'h10;
      checks++;
      if (who !== (k % 2) || (who == 0 && m0_rdata !== exp_data) || (who == 1 && m1_rdata !== exp_data)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got master %0d data %h/%h, required master %0d data %h",
                 k, who, m0_rdata, m1_rdata, k % 2, exp_data);
      end
    end
    m0_trans = 0; m1_trans = 0;
    @(negedge clock);
  endtask

  task automatic test_mode_write();
    int who, cyc;
    m1_trans = 1; m1_write = 1; m1_waddr = 8'h00; m1_wdata = 8'h01;
    wait_resp(10, who, cyc);
    checks++;
    if (who !== 1 || m1_err !== 1'b0) begin
      errors++;
      $display("FAIL mode_write: got master %0d err=%b, required master 1 err 0", who, m1_err);
    end
    m1_trans = 0; m1_write = 0;
    @(negedge clock);
    m0_trans = 1; m0_write = 0; m0_waddr = 8'h05;
    wait_resp(10, who, cyc);
    checks++;
    if (who !== 0 || m0_rdata !== 8'h10) begin
      errors++;
      $display("FAIL odd_read: got master %0d rdata=%h, required master 0 rdata 10", who, m0_rdata);
    end
    m0_trans = 0;
    @(negedge clock);
    m1_trans = 1; m1_write = 1; m1_waddr = 8'h00; m1_wdata = 8'h00;
    wait_resp(10, who, cyc);
    checks++;
    if (who !== 1) begin
      errors++;
      $display("FAIL mode_restore: got master %0d, required master 1", who);
    end
    m1_trans = 0; m1_write = 0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int who, cyc;
    mute = 1;
    m0_trans = 1; m0_write = 0; m0_waddr = 8'h10;
    wait_resp(30, who, cyc);
    checks++;
    if (who !== 0 || cyc !== 17 || m0_err !== 1'b1 || m0_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL timeout_resp: got master %0d cycle %0d err=%b rdata=%h, required master 0 cycle 17 err 1 rdata ff",
               who, cyc, m0_err, m0_rdata);
    end
    m0_trans = 0;
    @(negedge clock);
    checks++;
    if (m0_readyout !== 1'b0 || m0_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got m0_rdy=%b err=%b, required 0 0", m0_readyout, m0_err);
    end
    // Slave answers in the very cycle the timeout would expire: data must win.
    m0_trans = 1; m0_waddr = 8'h22;
    repeat (16) @(negedge clock);
    inj = 1; inj_data = 8'h5A;
    @(negedge clock);
    inj = 0;
    checks++;
    if (m0_readyout !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL timeout_race: got m0_rdy=%b err=%b rdata=%h, required 1 0 5a",
               m0_readyout, m0_err, m0_rdata);
    end
    m0_trans = 0; mute = 0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int who, cyc;
    logic seen;
    mute = 1;
    m0_trans = 1; m0_write = 0; m0_waddr = 8'h10;
    repeat (3) @(negedge clock);
    rst = 1; m0_trans = 0;
    @(negedge clock);
    checks++;
    if ({s_trans, s_waddr, m0_readyout, m0_err, m0_rdata, m1_readyout, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got s_trans=%b s_waddr=%h m0_rdy=%b m0_rdata=%h, required all 0",
               s_trans, s_waddr, m0_readyout, m0_rdata);
    end
    rst = 0; mute = 0;
    inj = 1; inj_data = 8'h77;
    @(negedge clock);
    inj = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (m0_readyout || m1_readyout) seen = 1;
      @(negedge clock);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL late_ready: got readyout pulse=%b, required 0", seen);
    end
    // After reset master 0 must win a tie again.
    m0_trans = 1; m0_waddr = 8'h40;
    m1_trans = 1; m1_waddr = 8'h60;
    @(negedge clock);
    checks++;
    if (s_trans !== 1'b1 || s_waddr !== 8'h40) begin
      errors++;
      $display("FAIL reset_tie: got s_trans=%b s_waddr=%h, required 1 40", s_trans, s_waddr);
    end
    wait_resp(10, who, cyc);
    checks++;
    if (who !== 0 || m0_rdata !== 8'h20) begin
      errors++;
      $display("FAIL reset_tie_resp: got master %0d rdata=%h, required master 0 rdata 20", who, m0_rdata);
    end
    m0_trans = 0; m1_trans = 0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_addr_stable();
    m0_trans = 1; m0_write = 0; m0_waddr = 8'h10;
    @(negedge clock);
    m0_waddr = 8'h30;
    @(negedge clock);
    checks++;
    if (s_waddr !== 8'h10) begin
      errors++;
      $display("FAIL addr_hold_wait: got s_waddr=%h, required 10", s_waddr);
    end
    @(negedge clock);
    checks++;
    if (m0_readyout !== 1'b1 || m0_rdata !== 8'h08 || s_waddr !== 8'h10) begin
      errors++;
      $display("FAIL addr_hold_resp: got m0_rdy=%b rdata=%h s_waddr=%h, required 1 08 10",
               m0_readyout, m0_rdata, s_waddr);
    end
    m0_trans = 0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_mode_write();
    test_timeout();
    test_reset_mid();
    test_addr_stable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
